// File: rtl/led_seq_ctrl_if.sv
// Override handshake bundle for the LED sequencer.
// master: the override requester (status/debug logic).
// slave:  led_seq_ctrl, which owns the LED bank.
// Handshake: the requester holds ovr_req high as a level; on each edge where
// the controller accepts (idle, or hold period expired), ovr_pattern is
// captured, ovr_ack pulses for exactly one cycle and ovr_active stays high
// until the hold period ends with ovr_req low.
interface led_seq_ctrl_if #(
    parameter int NUM_LEDS = 8
) ();
    logic                ovr_req;
    logic [NUM_LEDS-1:0] ovr_pattern;
    logic                ovr_ack;
    logic                ovr_active;

    modport master (
        output ovr_req,
        output ovr_pattern,
        input  ovr_ack,
        input  ovr_active
    );

    modport slave (
        input  ovr_req,
        input  ovr_pattern,
        output ovr_ack,
        output ovr_active
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED bank controller: background pattern sequencer (COUNT/SCAN/BLINK/OFF)
// stepped by a prescaler tick, plus an override owner with a minimum hold time.
// Optional feature macro: LED_SEQ_PWM_EN adds a 4-bit duty input and a
// free-running PWM that gates the registered LED drive.
module led_seq_ctrl #(
    parameter int TICK_DIV = 12500000,
    parameter int TICK_W   = 24,
    parameter int NUM_LEDS = 8,
    parameter int OVR_HOLD = 4
) (
    input  logic                sysclock,
    input  logic                sysreset,
    input  logic [1:0]          mode_sel,
    input  logic                mode_load,
    led_seq_ctrl_if.slave       ovr,
    output logic [1:0]          cur_mode,
    output logic                tick,
    output logic [NUM_LEDS-1:0] leds
`ifdef LED_SEQ_PWM_EN
    ,
    input  logic [3:0]          duty
`endif
);

    localparam int POS_W  = $clog2(NUM_LEDS);
    localparam int HOLD_W = $clog2(OVR_HOLD + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(NUM_LEDS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVR_HOLD);

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_OFF   = 2'd3
    } mode_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } ovr_state_t;

    mode_t               cur_mode_q;
    logic [TICK_W-1:0]   presc_q, presc_d;
    logic [NUM_LEDS-1:0] step_q, step_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_up_q, dir_up_d;
    logic                phase_q, phase_d;
    logic [NUM_LEDS-1:0] bg_pattern;
    logic                step_en;

    ovr_state_t          ovr_state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [NUM_LEDS-1:0] cap_q;
    logic                ack_q;
    logic                active_q;
    logic [NUM_LEDS-1:0] leds_q;

    // Tick is a pure decode of the prescaler register.
    assign tick    = (presc_q == TICK_LAST);
    // A tick landing on a mode_load edge must not advance the freshly cleared pattern.
    assign step_en = tick && !mode_load;

    // Prescaler next state: wrap on tick, restart on mode_load.
    always_comb begin
        presc_d = presc_q + TICK_W'(1);
        if (mode_load || tick) begin
            presc_d = '0;
        end
    end

    // Background pattern next state for the applied mode.
    always_comb begin
        step_d   = step_q;
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        phase_d  = phase_q;
        if (mode_load) begin
            step_d   = '0;
            pos_d    = '0;
            dir_up_d = 1'b1;
            phase_d  = 1'b0;
        end else if (step_en) begin
            case (cur_mode_q)
                MODE_COUNT: step_d = step_q + NUM_LEDS'(1);
                MODE_SCAN: begin
                    // Reverse at each end without repeating the end position.
                    if (dir_up_q) begin
                        if (pos_q == POS_LAST) begin
                            dir_up_d = 1'b0;
                            pos_d    = pos_q - POS_W'(1);
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_up_d = 1'b1;
                            pos_d    = pos_q + POS_W'(1);
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                end
                MODE_BLINK: phase_d = ~phase_q;
                default: ;
            endcase
        end
    end

    // Background pattern decode from the current pattern state.
    always_comb begin
        bg_pattern = '0;
        case (cur_mode_q)
            MODE_COUNT: bg_pattern = step_q;
            MODE_SCAN:  bg_pattern = NUM_LEDS'(1) << pos_q;
            MODE_BLINK: bg_pattern = {NUM_LEDS{phase_q}};
            default:    bg_pattern = '0;
        endcase
    end

    // Mode, prescaler and pattern state registers.
    always_ff @(posedge sysclock) begin
        if (sysreset) begin
            cur_mode_q <= MODE_COUNT;
            presc_q    <= '0;
            step_q     <= '0;
            pos_q      <= '0;
            dir_up_q   <= 1'b1;
            phase_q    <= 1'b0;
        end else begin
            if (mode_load) begin
                cur_mode_q <= mode_t'(mode_sel);
            end
            presc_q  <= presc_d;
            step_q   <= step_d;
            pos_q    <= pos_d;
            dir_up_q <= dir_up_d;
            phase_q  <= phase_d;
        end
    end

    // Override ownership FSM; also registers the LED drive so the override
    // pattern appears in the same cycle as its ack.
    always_ff @(posedge sysclock) begin
        if (sysreset) begin
            ovr_state_q <= ST_RUN;
            hold_q      <= '0;
            cap_q       <= '0;
            ack_q       <= 1'b0;
            active_q    <= 1'b0;
            leds_q      <= '0;
        end else begin
            ack_q <= 1'b0;
            case (ovr_state_q)
                ST_RUN: begin
                    if (ovr.ovr_req) begin
                        cap_q       <= ovr.ovr_pattern;
                        ack_q       <= 1'b1;
                        active_q    <= 1'b1;
                        hold_q      <= '0;
                        ovr_state_q <= ST_HOLD;
                        leds_q      <= ovr.ovr_pattern;
                    end else begin
                        leds_q <= bg_pattern;
                    end
                end
                ST_HOLD: begin
                    leds_q <= cap_q;
                    if (tick) begin
                        if ((hold_q + HOLD_W'(1)) == HOLD_LAST) begin
                            hold_q <= '0;
                            if (ovr.ovr_req) begin
                                cap_q  <= ovr.ovr_pattern;
                                ack_q  <= 1'b1;
                                leds_q <= ovr.ovr_pattern;
                            end else begin
                                active_q    <= 1'b0;
                                ovr_state_q <= ST_RUN;
                                leds_q      <= bg_pattern;
                            end
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                end
                default: ovr_state_q <= ST_RUN;
            endcase
        end
    end

    assign ovr.ovr_ack    = ack_q;
    assign ovr.ovr_active = active_q;
    assign cur_mode       = cur_mode_q;

`ifdef LED_SEQ_PWM_EN
    logic [3:0] pwm_cnt_q;

    // Free-running PWM phase counter.
    always_ff @(posedge sysclock) begin
        if (sysreset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
        end
    end

    assign leds = leds_q & {NUM_LEDS{pwm_cnt_q < duty}};
`else
    assign leds = leds_q;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=4, NUM_LEDS=8, OVR_HOLD=4.
// Cycle numbers count clock edges after reset release (cycle 0 = reset state).
module tb_led_seq_ctrl;
    localparam int N = 8;

    logic         sysclock = 1'b0;
    logic         sysreset = 1'b1;
    logic [1:0]   mode_sel = 2'd0;
    logic         mode_load = 1'b0;
    logic [1:0]   cur_mode;
    logic         tick;
    logic [N-1:0] leds;
`ifdef LED_SEQ_PWM_EN
    logic [3:0]   duty = 4'd15;
`endif

    led_seq_ctrl_if #(.NUM_LEDS(N)) ovr_if ();

    led_seq_ctrl #(
        .TICK_DIV (4),
        .TICK_W   (3),
        .NUM_LEDS (N),
        .OVR_HOLD (4)
    ) dut (
        .sysclock  (sysclock),
        .sysreset  (sysreset),
        .mode_sel  (mode_sel),
        .mode_load (mode_load),
        .ovr       (ovr_if),
        .cur_mode  (cur_mode),
        .tick      (tick),
        .leds      (leds)
`ifdef LED_SEQ_PWM_EN
        ,
        .duty      (duty)
`endif
    );

    always #5 sysclock = ~sysclock;

    int cyc    = 0;
    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int acks   = 0;
    int on_cnt = 0;

    logic [7:0] scan_exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    task automatic step();
        @(posedge sysclock);
        #1;
        cyc++;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        sysreset       = 1'b1;
        mode_load      = 1'b0;
        ovr_if.ovr_req = 1'b0;
        step();
        step();
        sysreset = 1'b0;
        cyc      = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected LED value as seen at the pins, including PWM gating when built in.
    function automatic logic [N-1:0] gate(input logic [N-1:0] v);
`ifdef LED_SEQ_PWM_EN
        return ((cyc % 16) < int'(duty)) ? v : '0;
`else
        return v;
`endif
    endfunction

    task automatic chk_leds(input string tag, input logic [N-1:0] exp);
        chk(tag, 32'(leds), 32'(gate(exp)));
    endtask

    initial begin
        ovr_if.ovr_req     = 1'b0;
        ovr_if.ovr_pattern = '0;

        // Reset values and COUNT mode from reset.
        do_reset();
        chk_leds("rst_leds", 8'h00);
        chk("rst_ack", 32'(ovr_if.ovr_ack), 32'd0);
        chk("rst_active", 32'(ovr_if.ovr_active), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_mode", 32'(cur_mode), 32'd0);
        goto_cyc(2);    chk("tick_c2", 32'(tick), 32'd0);
        goto_cyc(3);    chk("tick_first", 32'(tick), 32'd1);
        goto_cyc(4);    chk("tick_c4", 32'(tick), 32'd0);
        goto_cyc(5);    chk_leds("count_1", 8'h01);
        goto_cyc(7);    chk("tick_second", 32'(tick), 32'd1);
        goto_cyc(9);    chk_leds("count_2", 8'h02);
        goto_cyc(1021); chk_leds("count_ff", 8'hFF);
        goto_cyc(1025); chk_leds("count_wrap", 8'h00);

        // mode_load to BLINK mid-count, while leds show 0x13.
        do_reset();
        goto_cyc(78);   chk_leds("pre_blink", 8'h13);
        mode_sel  = 2'd2;
        mode_load = 1'b1;
        step();
        mode_load = 1'b0;
        chk("blink_mode", 32'(cur_mode), 32'd2);
        chk("blink_presc_restart", 32'(tick), 32'd0);
        goto_cyc(80);   chk_leds("blink_first", 8'h00);
        goto_cyc(82);   chk("blink_tick", 32'(tick), 32'd1);
        goto_cyc(84);   chk_leds("blink_on", 8'hFF);
        goto_cyc(88);   chk_leds("blink_off", 8'h00);
        goto_cyc(92);   chk_leds("blink_on2", 8'hFF);

        // SCAN sequence from a load right after reset.
        do_reset();
        mode_sel  = 2'd1;
        mode_load = 1'b1;
        step();
        mode_load = 1'b0;
        chk("scan_mode", 32'(cur_mode), 32'd1);
        goto_cyc(4);    chk("scan_tick", 32'(tick), 32'd1);
        for (int k = 0; k < 16; k++) begin
            goto_cyc(4 * k + 2);
            chk_leds($sformatf("scan_%0d", k), scan_exp[k]);
        end

        // Single-cycle override request at leds=0x05.
        do_reset();
        goto_cyc(24);   chk_leds("pre_ovr", 8'h05);
        ovr_if.ovr_req     = 1'b1;
        ovr_if.ovr_pattern = 8'hA5;
        step();
        ovr_if.ovr_req = 1'b0;
        chk("ovr_ack", 32'(ovr_if.ovr_ack), 32'd1);
        chk("ovr_active", 32'(ovr_if.ovr_active), 32'd1);
        chk_leds("ovr_leds", 8'hA5);
        acks = 1;
        while (cyc < 39) begin
            step();
            acks += int'(ovr_if.ovr_ack);
        end
        chk("ovr_hold_active", 32'(ovr_if.ovr_active), 32'd1);
        chk_leds("ovr_hold_leds", 8'hA5);
        step();
        acks += int'(ovr_if.ovr_ack);
        chk("ovr_exit_active", 32'(ovr_if.ovr_active), 32'd0);
        chk_leds("ovr_exit_leds", 8'h09);
        chk("ovr_ack_count", 32'(acks), 32'd1);
        step();
        chk_leds("ovr_after_leds", 8'h0A);

        // Held request: re-accept every OVR_HOLD ticks, new pattern only at re-accept.
        do_reset();
        ovr_if.ovr_req     = 1'b1;
        ovr_if.ovr_pattern = 8'h3C;
        step();
        chk("held_ack1", 32'(ovr_if.ovr_ack), 32'd1);
        chk_leds("held_leds1", 8'h3C);
        ovr_if.ovr_pattern = 8'hC3;
        step();
        chk("held_ack_drop", 32'(ovr_if.ovr_ack), 32'd0);
        goto_cyc(15);
        chk("held_pre_ack", 32'(ovr_if.ovr_ack), 32'd0);
        chk_leds("held_pre_leds", 8'h3C);
        goto_cyc(16);
        chk("held_ack2", 32'(ovr_if.ovr_ack), 32'd1);
        chk_leds("held_leds2", 8'hC3);
        goto_cyc(31);   chk("held_c31_ack", 32'(ovr_if.ovr_ack), 32'd0);
        goto_cyc(32);   chk("held_ack3", 32'(ovr_if.ovr_ack), 32'd1);
        ovr_if.ovr_req = 1'b0;
        goto_cyc(47);   chk("held_active_end", 32'(ovr_if.ovr_active), 32'd1);
        goto_cyc(48);
        chk("held_exit_active", 32'(ovr_if.ovr_active), 32'd0);
        chk_leds("held_exit_leds", 8'h0B);

        // mode_load with ovr_req on the same edge, then reset during HOLD.
        do_reset();
        ovr_if.ovr_req     = 1'b1;
        ovr_if.ovr_pattern = 8'h5A;
        mode_sel           = 2'd3;
        mode_load          = 1'b1;
        step();
        mode_load      = 1'b0;
        ovr_if.ovr_req = 1'b0;
        chk("both_mode", 32'(cur_mode), 32'd3);
        chk("both_ack", 32'(ovr_if.ovr_ack), 32'd1);
        chk_leds("both_leds", 8'h5A);
        step();
        chk_leds("hold_over_off", 8'h5A);
        sysreset = 1'b1;
        step();
        sysreset = 1'b0;
        chk_leds("abort_leds", 8'h00);
        chk("abort_active", 32'(ovr_if.ovr_active), 32'd0);
        chk("abort_ack", 32'(ovr_if.ovr_ack), 32'd0);
        chk("abort_mode", 32'(cur_mode), 32'd0);

`ifdef LED_SEQ_PWM_EN
        // duty=8 on an all-ones override: on for 8 of every 16 cycles.
        do_reset();
        duty               = 4'd8;
        ovr_if.ovr_req     = 1'b1;
        ovr_if.ovr_pattern = 8'hFF;
        step();
        on_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (leds != '0) on_cnt++;
        end
        chk("pwm_on_cycles", 32'(on_cnt), 32'd8);
        ovr_if.ovr_req = 1'b0;
        duty           = 4'd15;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
